// File: rtl/pipe_seg_adder_pkg.sv
// Shared configuration helpers for the segmented pipelined adder.
package pipe_seg_adder_pkg;

    // Legal geometry: positive segment width that evenly tiles the operand.
    function automatic bit cfg_ok(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/seg_rca.sv
// One SEG-bit ripple segment; also exposes the carry into its MSB for overflow detection.
module seg_rca #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           cmsb
);

    logic [SEG:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    assign s    = full[SEG-1:0];
    assign co   = full[SEG];
    // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the sum bit.
    assign cmsb = full[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_seg_adder.sv
// Pipelined add/subtract: one SEG-bit ripple segment per stage, valid/ready flow control.
module pipe_seg_adder
    import pipe_seg_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = WIDTH / SEG;

    if (!cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("pipe_seg_adder: WIDTH must be a positive multiple of SEG");
    end

    logic [NSTG-1:0]  vld;
    logic [NSTG-1:0]  rdy;
    logic [WIDTH-1:0] a_st  [NSTG];
    logic [WIDTH-1:0] b_st  [NSTG];
    logic [WIDTH-1:0] s_st  [NSTG];
    logic             c_st  [NSTG];
    logic             ovf_q;

    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] nxt_s  [NSTG];
    logic [SEG-1:0]   seg_a  [NSTG];
    logic [SEG-1:0]   seg_b  [NSTG];
    logic [SEG-1:0]   seg_s  [NSTG];
    logic             seg_ci [NSTG];
    logic             seg_co [NSTG];
    logic             seg_cm [NSTG];

    assign b_in = sub ? ~b : b;

    // A stage may load if it is empty or everything downstream of it will move.
    always_comb begin : p_ready
        logic acc;
        acc = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            acc    = acc | ~vld[k];
            rdy[k] = acc;
        end
    end

    always_comb begin
        seg_a[0]  = a[SEG-1:0];
        seg_b[0]  = b_in[SEG-1:0];
        seg_ci[0] = cin;
        for (int k = 1; k < NSTG; k++) begin
            seg_a[k]  = a_st[k-1][k*SEG +: SEG];
            seg_b[k]  = b_st[k-1][k*SEG +: SEG];
            seg_ci[k] = c_st[k-1];
        end
    end

    for (genvar g = 0; g < NSTG; g++) begin : g_seg
        seg_rca #(.SEG(SEG)) u_seg (
            .a    (seg_a[g]),
            .b    (seg_b[g]),
            .ci   (seg_ci[g]),
            .s    (seg_s[g]),
            .co   (seg_co[g]),
            .cmsb (seg_cm[g])
        );
    end

    always_comb begin
        nxt_s[0]          = '0;
        nxt_s[0][SEG-1:0] = seg_s[0];
        for (int k = 1; k < NSTG; k++) begin
            nxt_s[k]               = s_st[k-1];
            nxt_s[k][k*SEG +: SEG] = seg_s[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                a_st[k] <= '0;
                b_st[k] <= '0;
                s_st[k] <= '0;
                c_st[k] <= 1'b0;
            end
        end else begin
            if (rdy[0]) begin
                vld[0]  <= in_valid;
                a_st[0] <= a;
                b_st[0] <= b_in;
            end
            for (int k = 1; k < NSTG; k++) begin
                if (rdy[k]) begin
                    vld[k]  <= vld[k-1];
                    a_st[k] <= a_st[k-1];
                    b_st[k] <= b_st[k-1];
                end
            end
            for (int k = 0; k < NSTG; k++) begin
                if (rdy[k]) begin
                    s_st[k] <= nxt_s[k];
                    c_st[k] <= seg_co[k];
                end
            end
            if (rdy[NSTG-1]) begin
                ovf_q <= seg_cm[NSTG-1] ^ seg_co[NSTG-1];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[NSTG-1];
    assign sum       = s_st[NSTG-1];
    assign cout      = c_st[NSTG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_seg_adder.sv
// Self-checking bench for pipe_seg_adder (WIDTH=32, SEG=8) against an arithmetic reference model.
module tb_pipe_seg_adder;

    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSTG  = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_retired = 0;
    logic [WIDTH+1:0] exp_q [$];

    pipe_seg_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic, packed as {sum, cout, ovf}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c, input logic s);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   w;
        logic             v;
        yy = s ? ~y : y;
        w  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c};
        v  = (x[WIDTH-1] == yy[WIDTH-1]) && (w[WIDTH-1] != x[WIDTH-1]);
        return {w[WIDTH-1:0], w[WIDTH], v};
    endfunction

    // Inputs are set just after a falling edge; handshakes are judged 1 time unit later.
    task automatic tick();
        logic [WIDTH+1:0] e;
        #1;
        if (out_valid && out_ready) begin
            check("retire_has_pending", {63'b0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("result", {30'b0, sum, cout, ovf}, {30'b0, e});
                n_retired++;
            end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
        @(negedge clk);
    endtask

    task automatic rand_ops();
        a   = $urandom;
        b   = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic run_one(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc,
                           input logic xs, input logic [WIDTH+1:0] want, input string tag);
        int n;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(NSTG));
        check(tag, {30'b0, sum, cout, ovf}, {30'b0, want});
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int accepted;
        int first_drop;
        int start_ret;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_sum", {32'b0, sum}, 64'd0);
        check("rst_cout_ovf", {62'b0, cout, ovf}, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);

        run_one(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0100, 1'b0, 1'b0}, "add_ff_1");
        run_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {32'h0000_0000, 1'b1, 1'b0}, "full_ripple");
        run_one(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1}, "sub_ovf");
        run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1}, "add_ovf");

        // Backpressure: 10 ops back-to-back, consumer stalled for cycles 3..8.
        accepted = 0; first_drop = -1; start_ret = n_retired;
        rand_ops();
        in_valid = 1'b1;
        for (cyc = 0; cyc < 60 && accepted < 10; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 8);
            #1;
            if (!in_ready && first_drop < 0) begin
                first_drop = cyc;
                check("bp_occupancy_at_stall", 64'(exp_q.size()), 64'(NSTG));
            end
            #0;
            if (in_ready) begin
                accepted++;
                tick();
                rand_ops();
                in_valid = (accepted < 10);
            end else begin
                tick();
            end
        end
        check("bp_in_ready_dropped", {63'b0, first_drop >= 0}, 64'd1);
        drain("bp");
        check("bp_result_count", 64'(n_retired - start_ret), 64'd10);

        // Bubbles with random consumer readiness.
        start_ret = n_retired;
        for (cyc = 0; cyc < 40; cyc++) begin
            rand_ops();
            in_valid  = (cyc % 2 == 0);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("bubble");
        check("bubble_results_seen", {63'b0, (n_retired - start_ret) > 0}, 64'd1);

        // Fully random traffic, including simultaneous accept and retire.
        for (cyc = 0; cyc < 200; cyc++) begin
            rand_ops();
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drain("random");

        // Reset mid-flight: three ops held in the pipe, then rst between edges.
        out_ready = 1'b0;
        for (cyc = 0; cyc < 3; cyc++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_sum", {32'b0, sum}, 64'd0);
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 8; cyc++) begin
            #1;
            check("post_rst_no_stale", {63'b0, out_valid}, 64'd0);
            @(negedge clk);
        end
        run_one(32'h1234_5678, 32'h0000_0008, 1'b1, 1'b1, {32'h1234_5670, 1'b1, 1'b0}, "post_rst_sub");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
